axi4_slave_write_responder: RTL and testbench
=============================================

AXI4_SLAVE_WRITE_RESPONDER -- requirements
Module: axi4_slave_write_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32: AWADDR and mem_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: WDATA width; STROBE_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter ID_WIDTH, default 4: AWID/BID width.
REQ-004 aclk  input  1  sole clock; all logic on rising edge.
REQ-005 aresetn  input  1  reset, synchronous, active-low.
REQ-006 awid/awaddr/awlen/awsize/awburst  input  ID_WIDTH/ADDRESS_WIDTH/8/3/2  write-address fields.
REQ-007 awvalid input 1, awready output 1: AW handshake.
REQ-008 wdata/wstrb/wlast  input  DATA_WIDTH/STROBE_WIDTH/1  write-data fields.
REQ-009 wvalid input 1, wready output 1: W handshake.
REQ-010 bid/bresp  output  ID_WIDTH/2  write response, encoded as bresp_enum.
REQ-011 bvalid output 1, bready input 1: B handshake.
REQ-012 mem_we/mem_addr/mem_wdata/mem_wstrb  output  1/ADDRESS_WIDTH/DATA_WIDTH/STROBE_WIDTH  registered memory write port.

Function
REQ-013 SHALL run FSM IDLE -> DATA -> RESP -> IDLE; one outstanding write transaction at a time.
REQ-014 IDLE: awready=1; on awvalid&awready, capture all AW fields, zero beat counter, go to DATA next cycle.
REQ-015 DATA: wready=1; each wvalid&wready is one beat.
REQ-016 For each accepted beat in a legal burst, mem_we SHALL be 1 in the following cycle, with mem_addr/mem_wdata/mem_wstrb taken from that beat; otherwise mem_we=0.
REQ-017 Beat address generation:
- FIXED: every beat uses AWADDR.
- INCR: beat n uses (AWADDR aligned to 2^AWSIZE) + n*2^AWSIZE; beat 0 uses AWADDR unaligned.
- WRAP: base = AWADDR & ~((AWLEN+1)*2^AWSIZE - 1); address wraps to base on reaching base + (AWLEN+1)*2^AWSIZE.
- Arithmetic is modulo 2^ADDRESS_WIDTH.
REQ-018 Burst SHALL be illegal if any of the following holds:
- AWBURST == WRITE_RESERVED;
- 2^AWSIZE > STROBE_WIDTH;
- WRAP with AWLEN not in {1,3,7,15};
- INCR crossing a 4 KB boundary.
An illegal burst SHALL still consume its W beats, with mem_we held 0.
REQ-019 The beat with index AWLEN SHALL end the burst whether or not wlast is set; a missing wlast there SHALL set the error flag.
REQ-020 wlast=1 on a beat with index < AWLEN SHALL end the burst early and set the error flag.
REQ-021 When the burst ends, go to RESP the next cycle.
REQ-022 RESP:
- bvalid=1, bid=captured AWID;
- bresp=WRITE_SLVERR if illegal or error flag, else WRITE_OKAY;
- hold all B outputs stable until bready; the cycle after bvalid&bready, return to IDLE.
REQ-023 Latency: AW handshake to wready=1 is one cycle; last beat to bvalid=1 is one cycle; B handshake to awready=1 is one cycle.
REQ-024 wready SHALL be 0 outside DATA; W beats presented while wready=0 are not consumed.
REQ-025 awready SHALL be 0 outside IDLE.
REQ-026 WRITE_EXOKAY is never returned; exclusive access is treated as normal access.

Reset
REQ-027 While aresetn=0 at a clock edge, the state SHALL become IDLE and these outputs SHALL be 0: awready, wready, bvalid, bid, bresp, mem_we, mem_addr, mem_wdata, mem_wstrb.
REQ-028 Reset mid-burst or mid-response SHALL abandon the transaction: no further mem_we, no B response; awready=1 from the first cycle after release.

Structure
REQ-029 awburst_type_enum, awsize_enum, bresp_enum and ADDRESS_WIDTH/DATA_WIDTH/STROBE_WIDTH SHALL come from axi4_globals_pkg; the FSM state enum SHALL also be added to it.
REQ-030 Beat address calculation SHALL be a combinational sub-module axi4_wr_addr_gen.
- Inputs: start address, len, size, burst, beat index.
- Outputs: beat address, illegal flag.

Verification
REQ-031 INCR, AWADDR=0x100, AWLEN=3, AWSIZE=2, AWID=5 -> mem_we on 4 cycles at 0x100/0x104/0x108/0x10C; BID=5, BRESP=OKAY.
REQ-032 WRAP, AWADDR=0x38, AWLEN=3, AWSIZE=2 -> mem_addr 0x38, 0x3C, 0x30, 0x34; BRESP=OKAY.
REQ-033 FIXED, AWADDR=0x20, AWLEN=2 -> three writes at 0x20; AWBURST=2'b11 -> zero mem_we, BRESP=SLVERR.
REQ-034 AWLEN=3 with wlast on beat 1 -> 2 writes, BRESP=SLVERR; AWLEN=1 with no wlast -> 2 writes, BRESP=SLVERR.
REQ-035 bready held 0 for 5 cycles -> bvalid/bid/bresp stable, awready=0; aresetn=0 on beat 2 of AWLEN=7 -> no further mem_we, no bvalid, awready=1 after release.

Source files
------------

// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 write-channel types and default widths for the write responder slice.
package axi4_globals_pkg;

   localparam int ADDRESS_WIDTH = 32;
   localparam int DATA_WIDTH    = 32;
   localparam int STROBE_WIDTH  = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      WRITE_FIXED    = 2'b00,
      WRITE_INCR     = 2'b01,
      WRITE_WRAP     = 2'b10,
      WRITE_RESERVED = 2'b11
   } awburst_type_enum;

   typedef enum logic [2:0] {
      SIZE_1B   = 3'd0,
      SIZE_2B   = 3'd1,
      SIZE_4B   = 3'd2,
      SIZE_8B   = 3'd3,
      SIZE_16B  = 3'd4,
      SIZE_32B  = 3'd5,
      SIZE_64B  = 3'd6,
      SIZE_128B = 3'd7
   } awsize_enum;

   typedef enum logic [1:0] {
      WRITE_OKAY   = 2'b00,
      WRITE_EXOKAY = 2'b01,
      WRITE_SLVERR = 2'b10,
      WRITE_DECERR = 2'b11
   } bresp_enum;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } wr_state_enum;

endpackage

// File: rtl/axi4_wr_addr_gen.sv
// Combinational beat address generator for FIXED/INCR/WRAP bursts, plus burst legality.
module axi4_wr_addr_gen #(
   parameter int ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH,
   parameter int STROBE_WIDTH  = axi4_globals_pkg::STROBE_WIDTH
) (
   input  logic [ADDRESS_WIDTH-1:0]           start_addr,
   input  logic [7:0]                         len,
   input  axi4_globals_pkg::awsize_enum       size,
   input  axi4_globals_pkg::awburst_type_enum burst,
   input  logic [7:0]                         beat,
   output logic [ADDRESS_WIDTH-1:0]           beat_addr,
   output logic                               illegal
);
   import axi4_globals_pkg::*;

   typedef logic [ADDRESS_WIDTH-1:0] addr_t;

   addr_t bytes;
   addr_t aligned;
   addr_t step;
   addr_t total;
   addr_t wrap_base;
   addr_t last_byte;
   logic  wrap_len_ok;

   always_comb begin
      bytes       = addr_t'(1) << size;
      aligned     = start_addr & ~(bytes - addr_t'(1));
      step        = addr_t'(beat) << size;
      total       = addr_t'({1'b0, len} + 9'd1) << size;
      wrap_base   = start_addr & ~(total - addr_t'(1));
      last_byte   = aligned + total - addr_t'(1);
      wrap_len_ok = len inside {8'd1, 8'd3, 8'd7, 8'd15};

      // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
      beat_addr = start_addr;
      case (burst)
         WRITE_INCR: if (beat != 8'd0) beat_addr = aligned + step;
         // Wrap length is a power of two, so the modulo is a mask.
         WRITE_WRAP: if (beat != 8'd0)
            beat_addr = wrap_base + ((aligned - wrap_base + step) & (total - addr_t'(1)));
         default: ;
      endcase

      illegal = (burst == WRITE_RESERVED)
             || (bytes > addr_t'(STROBE_WIDTH))
             || ((burst == WRITE_WRAP) && !wrap_len_ok)
             || ((burst == WRITE_INCR) &&
                 (start_addr[ADDRESS_WIDTH-1:12] != last_byte[ADDRESS_WIDTH-1:12]));
   end

endmodule

// File: rtl/axi4_slave_write_responder.sv
// AXI4 write slave: one transaction at a time, forwards legal beats to a registered memory port.
module axi4_slave_write_responder #(
   parameter  int ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH,
   parameter  int DATA_WIDTH    = axi4_globals_pkg::DATA_WIDTH,
   parameter  int ID_WIDTH      = 4,
   localparam int STROBE_WIDTH  = DATA_WIDTH / 8
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [ID_WIDTH-1:0]      awid,
   input  logic [ADDRESS_WIDTH-1:0] awaddr,
   input  logic [7:0]               awlen,
   input  logic [2:0]               awsize,
   input  logic [1:0]               awburst,
   input  logic                     awvalid,
   output logic                     awready,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [STROBE_WIDTH-1:0]  wstrb,
   input  logic                     wlast,
   input  logic                     wvalid,
   output logic                     wready,
   output logic [ID_WIDTH-1:0]      bid,
   output logic [1:0]               bresp,
   output logic                     bvalid,
   input  logic                     bready,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic [STROBE_WIDTH-1:0]  mem_wstrb
);
   import axi4_globals_pkg::*;

   wr_state_enum               state, next_state;
   logic [ID_WIDTH-1:0]        cap_id;
   logic [ADDRESS_WIDTH-1:0]   cap_addr;
   logic [7:0]                 cap_len;
   awsize_enum                 cap_size;
   awburst_type_enum           cap_burst;
   logic [7:0]                 beat_cnt;
   logic                       err_flag;
   logic [ADDRESS_WIDTH-1:0]   beat_addr;
   logic                       illegal;
   logic                       aw_fire, w_fire, b_fire, burst_end, beat_err;

   axi4_wr_addr_gen #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .STROBE_WIDTH  (STROBE_WIDTH)
   ) u_addr_gen (
      .start_addr (cap_addr),
      .len        (cap_len),
      .size       (cap_size),
      .burst      (cap_burst),
      .beat       (beat_cnt),
      .beat_addr  (beat_addr),
      .illegal    (illegal)
   );

   always_comb begin
      aw_fire   = awvalid && awready;
      w_fire    = wvalid && wready;
      b_fire    = bvalid && bready;
      // wlast must coincide exactly with beat index AWLEN; either mismatch is an error.
      beat_err  = (beat_cnt == cap_len) ? !wlast : wlast;
      burst_end = w_fire && (wlast || (beat_cnt == cap_len));

      next_state = state;
      case (state)
         ST_IDLE: if (aw_fire)   next_state = ST_DATA;
         ST_DATA: if (burst_end) next_state = ST_RESP;
         ST_RESP: if (b_fire)    next_state = ST_IDLE;
         default:                next_state = ST_IDLE;
      endcase
   end

   // Handshake outputs are registered from next_state so they read 0 during reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state     <= ST_IDLE;
         awready   <= 1'b0;
         wready    <= 1'b0;
         bvalid    <= 1'b0;
         bid       <= '0;
         bresp     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
         cap_id    <= '0;
         cap_addr  <= '0;
         cap_len   <= '0;
         cap_size  <= SIZE_1B;
         cap_burst <= WRITE_FIXED;
         beat_cnt  <= '0;
         err_flag  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state   <= next_state;
         awready <= (next_state == ST_IDLE);
         wready  <= (next_state == ST_DATA);
         bvalid  <= (next_state == ST_RESP);
         mem_we  <= 1'b0;

         if (aw_fire) begin
            cap_id    <= awid;
            cap_addr  <= awaddr;
            cap_len   <= awlen;
            cap_size  <= awsize_enum'(awsize);
            cap_burst <= awburst_type_enum'(awburst);
            beat_cnt  <= '0;
            err_flag  <= 1'b0;
         end

         if (w_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (beat_err) err_flag <= 1'b1;
            if (!illegal) begin
               mem_we    <= 1'b1;
               mem_addr  <= beat_addr;
               mem_wdata <= wdata;
               mem_wstrb <= wstrb;
            end
            if (burst_end) begin
               bid   <= cap_id;
               bresp <= (illegal || err_flag || beat_err) ? WRITE_SLVERR : WRITE_OKAY;
            end
         end
      end
   end

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Randomized and directed bench for axi4_slave_write_responder against a queue-based model.
module tb_axi4_slave_write_responder;
   import axi4_globals_pkg::*;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [3:0]  awid = '0;
   logic [31:0] awaddr = '0;
   logic [7:0]  awlen = '0;
   logic [2:0]  awsize = '0;
   logic [1:0]  awburst = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wlast = 1'b0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;

   axi4_slave_write_responder #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .ID_WIDTH      (4)
   ) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .awid      (awid),
      .awaddr    (awaddr),
      .awlen     (awlen),
      .awsize    (awsize),
      .awburst   (awburst),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wlast     (wlast),
      .wvalid    (wvalid),
      .wready    (wready),
      .bid       (bid),
      .bresp     (bresp),
      .bvalid    (bvalid),
      .bready    (bready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb)
   );

   always #5 aclk = ~aclk;

   typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } wr_t;
   typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;

   wr_t exp_w[$];
   b_t  exp_b[$];
   wr_t e;
   b_t  eb;
   int  vectors = 0;
   int  miscompares = 0;
   int  we_count = 0;
   bit  cmp_en = 1'b0;

   logic [31:0] cur_addr;
   int          cur_len, cur_size, cur_burst;
   bit          cur_illegal;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: addresses straight from the burst rules using integer division and modulo.
   function automatic logic [31:0] m_addr(input logic [31:0] a, input int len, input int size,
                                          input int burst, input int n);
      longint unsigned aa, bytes, total, al, base, nn;
      aa    = 64'(a);
      nn    = 64'(n);
      bytes = 64'd1 << size;
      total = 64'(len + 1) * bytes;
      al    = (aa / bytes) * bytes;
      if (n == 0 || burst == 0 || burst == 3) return a;
      if (burst == 1) return 32'(al + nn * bytes);
      base = (aa / total) * total;
      return 32'(base + ((al - base + nn * bytes) % total));
   endfunction

   function automatic bit m_illegal(input logic [31:0] a, input int len, input int size, input int burst);
      longint unsigned aa, bytes, last;
      aa    = 64'(a);
      bytes = 64'd1 << size;
      if (burst == 3) return 1'b1;
      if (bytes > 64'd4) return 1'b1;
      if (burst == 2 && !(len inside {1, 3, 7, 15})) return 1'b1;
      if (burst == 1) begin
         last = (aa / bytes) * bytes + 64'(len + 1) * bytes - 64'd1;
         if ((aa >> 12) != (last >> 12)) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Every cycle: writes must match the expected queue in order, B outputs must match its head.
   always @(negedge aclk) begin
      if (cmp_en) begin
         if (mem_we === 1'b1) begin
            we_count++;
            if (exp_w.size() == 0) check("we_expected", 64'(mem_we), 64'd0);
            else begin
               e = exp_w.pop_front();
               check("mem_addr", 64'(mem_addr), 64'(e.addr));
               check("mem_wdata", 64'(mem_wdata), 64'(e.data));
               check("mem_wstrb", 64'(mem_wstrb), 64'(e.strb));
            end
         end
         if (bvalid === 1'b1) begin
            if (exp_b.size() == 0) check("bvalid_expected", 64'(bvalid), 64'd0);
            else begin
               eb = exp_b[0];
               check("bid", 64'(bid), 64'(eb.id));
               check("bresp", 64'(bresp), 64'(eb.resp));
               if (bready) void'(exp_b.pop_front());
            end
         end
         check("one_channel_ready", 64'($countones({awready, wready, bvalid}) <= 1), 64'd1);
      end
   end

   task automatic check_reset_outputs();
      check("rst_awready", 64'(awready), 64'd0);
      check("rst_wready", 64'(wready), 64'd0);
      check("rst_bvalid", 64'(bvalid), 64'd0);
      check("rst_bid", 64'(bid), 64'd0);
      check("rst_bresp", 64'(bresp), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
   endtask

   // All driver tasks start and end just after a rising edge.
   task automatic aw_phase(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst);
      if ($urandom_range(0, 3) == 0) begin
         wvalid = 1'b1;
         wdata  = $urandom;
         repeat (2) begin @(posedge aclk); #1; end
         wvalid = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
      awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
      awvalid = 1'b1;
      for (int k = 0; ; k++) begin
         @(negedge aclk);
         if (awready) break;
         if (k == 20) begin check("awready_wait", 64'(awready), 64'd1); break; end
      end
      @(posedge aclk); #1;
      awvalid     = 1'b0;
      cur_addr    = addr;
      cur_len     = len;
      cur_size    = size;
      cur_burst   = burst;
      cur_illegal = m_illegal(addr, len, size, burst);
      @(negedge aclk);
      check("aw_to_wready", 64'(wready), 64'd1);
      check("awready_in_data", 64'(awready), 64'd0);
      @(posedge aclk); #1;
   endtask

   task automatic send_beat(input int idx, input bit last);
      if ($urandom_range(0, 3) == 0) begin
         wvalid = 1'b0;
         repeat ($urandom_range(1, 2)) begin @(posedge aclk); #1; end
      end
      wvalid = 1'b1;
      wdata  = $urandom;
      wstrb  = 4'($urandom);
      wlast  = last;
      if (!cur_illegal)
         exp_w.push_back('{addr: m_addr(cur_addr, cur_len, cur_size, cur_burst, idx),
                           data: wdata, strb: wstrb});
      for (int k = 0; ; k++) begin
         @(negedge aclk);
         if (wready) break;
         if (k == 20) begin check("wready_wait", 64'(wready), 64'd1); break; end
      end
      @(posedge aclk); #1;
      wvalid = 1'b0;
      wlast  = 1'b0;
   endtask

   task automatic b_phase(input int bdelay, output logic [3:0] g_id, output logic [1:0] g_resp);
      @(negedge aclk);
      check("last_to_bvalid", 64'(bvalid), 64'd1);
      check("wready_in_resp", 64'(wready), 64'd0);
      g_id   = bid;
      g_resp = bresp;
      repeat (bdelay) begin
         @(posedge aclk); #1;
         wvalid = 1'($urandom);
         @(negedge aclk);
         check("awready_in_resp", 64'(awready), 64'd0);
         check("bid_hold", 64'(bid), 64'(g_id));
      end
      @(posedge aclk); #1;
      wvalid = 1'b0;
      bready = 1'b1;
      @(negedge aclk);
      @(posedge aclk); #1;
      bready = 1'b0;
      @(negedge aclk);
      check("b_to_awready", 64'(awready), 64'd1);
      check("bvalid_after_b", 64'(bvalid), 64'd0);
      @(posedge aclk); #1;
   endtask

   task automatic run_txn(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int early, input bit drop,
                          input int bdelay, output logic [3:0] g_id, output logic [1:0] g_resp,
                          output int wd);
      int nb, w0;
      w0 = we_count;
      aw_phase(id, addr, len, size, burst);
      nb = (early >= 0) ? early + 1 : len + 1;
      for (int i = 0; i < nb; i++) send_beat(i, (i == nb - 1) && !drop);
      exp_b.push_back('{id: id,
                        resp: (cur_illegal || early >= 0 || drop) ? 2'b10 : 2'b00});
      b_phase(bdelay, g_id, g_resp);
      wd = we_count - w0;
      check("writes_drained", 64'(exp_w.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  g_id;
      logic [1:0]  g_resp;
      int          wd, w0;
      logic [31:0] lit[4];
      int          wl[4];
      int          burst, size, len, mode, early;
      logic [31:0] addr;

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      check_reset_outputs();
      @(posedge aclk); #1;
      aresetn = 1'b1;
      cmp_en  = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check("awready_after_reset", 64'(awready), 64'd1);
      @(posedge aclk); #1;

      // INCR 0x100, 4 beats of 4 bytes
      lit = '{32'h100, 32'h104, 32'h108, 32'h10C};
      for (int k = 0; k < 4; k++) check("model_incr_addr", 64'(m_addr(32'h100, 3, 2, 1, k)), 64'(lit[k]));
      run_txn(4'd5, 32'h100, 3, 2, 1, -1, 1'b0, 0, g_id, g_resp, wd);
      check("incr_writes", 64'(wd), 64'd4);
      check("incr_bid", 64'(g_id), 64'd5);
      check("incr_bresp", 64'(g_resp), 64'(WRITE_OKAY));

      // WRAP 0x38, 4 beats of 4 bytes
      lit = '{32'h38, 32'h3C, 32'h30, 32'h34};
      for (int k = 0; k < 4; k++) check("model_wrap_addr", 64'(m_addr(32'h38, 3, 2, 2, k)), 64'(lit[k]));
      run_txn(4'd2, 32'h38, 3, 2, 2, -1, 1'b0, 1, g_id, g_resp, wd);
      check("wrap_writes", 64'(wd), 64'd4);
      check("wrap_bresp", 64'(g_resp), 64'(WRITE_OKAY));

      // FIXED 0x20, 3 beats
      for (int k = 0; k < 3; k++) check("model_fixed_addr", 64'(m_addr(32'h20, 2, 2, 0, k)), 64'h20);
      run_txn(4'd7, 32'h20, 2, 2, 0, -1, 1'b0, 0, g_id, g_resp, wd);
      check("fixed_writes", 64'(wd), 64'd3);
      check("fixed_bresp", 64'(g_resp), 64'(WRITE_OKAY));

      // Reserved burst type: beats consumed, nothing written
      run_txn(4'd1, 32'h20, 2, 2, 3, -1, 1'b0, 0, g_id, g_resp, wd);
      check("reserved_writes", 64'(wd), 64'd0);
      check("reserved_bresp", 64'(g_resp), 64'(WRITE_SLVERR));

      // Early wlast on beat 1 of 4
      run_txn(4'd3, 32'h200, 3, 2, 1, 1, 1'b0, 0, g_id, g_resp, wd);
      check("early_wlast_writes", 64'(wd), 64'd2);
      check("early_wlast_bresp", 64'(g_resp), 64'(WRITE_SLVERR));

      // Missing wlast on final beat of 2
      run_txn(4'd4, 32'h300, 1, 2, 1, -1, 1'b1, 0, g_id, g_resp, wd);
      check("no_wlast_writes", 64'(wd), 64'd2);
      check("no_wlast_bresp", 64'(g_resp), 64'(WRITE_SLVERR));

      // Back-pressure on B for 5 cycles
      run_txn(4'd9, 32'h400, 1, 2, 1, -1, 1'b0, 5, g_id, g_resp, wd);
      check("stall_bid", 64'(g_id), 64'd9);
      check("stall_bresp", 64'(g_resp), 64'(WRITE_OKAY));

      // Unaligned INCR start: only beat 0 keeps the unaligned address
      lit = '{32'h102, 32'h104, 32'h108, 32'h0};
      for (int k = 0; k < 3; k++) check("model_unaligned_addr", 64'(m_addr(32'h102, 2, 2, 1, k)), 64'(lit[k]));
      run_txn(4'd6, 32'h102, 2, 2, 1, -1, 1'b0, 0, g_id, g_resp, wd);
      check("unaligned_writes", 64'(wd), 64'd3);

      // 4 KB boundary: ending exactly at 0xFFF is legal, crossing it is not
      check("model_4k_edge", 64'(m_illegal(32'hFF0, 3, 2, 1)), 64'd0);
      check("model_4k_cross", 64'(m_illegal(32'hFF8, 3, 2, 1)), 64'd1);
      run_txn(4'd8, 32'hFF0, 3, 2, 1, -1, 1'b0, 0, g_id, g_resp, wd);
      check("4k_edge_writes", 64'(wd), 64'd4);
      check("4k_edge_bresp", 64'(g_resp), 64'(WRITE_OKAY));
      run_txn(4'd8, 32'hFF8, 3, 2, 1, -1, 1'b0, 0, g_id, g_resp, wd);
      check("4k_cross_writes", 64'(wd), 64'd0);
      check("4k_cross_bresp", 64'(g_resp), 64'(WRITE_SLVERR));

      // Beat wider than the data bus, and a WRAP of 3 beats
      run_txn(4'd10, 32'h500, 0, 3, 1, -1, 1'b0, 0, g_id, g_resp, wd);
      check("oversize_bresp", 64'(g_resp), 64'(WRITE_SLVERR));
      run_txn(4'd11, 32'h500, 2, 2, 2, -1, 1'b0, 0, g_id, g_resp, wd);
      check("wrap_len2_bresp", 64'(g_resp), 64'(WRITE_SLVERR));
      check("wrap_len2_writes", 64'(wd), 64'd0);

      // Reset while beat 2 of an 8-beat burst is on the bus
      aw_phase(4'd12, 32'h600, 7, 2, 1);
      send_beat(0, 1'b0);
      send_beat(1, 1'b0);
      aresetn = 1'b0;
      wvalid  = 1'b1;
      wdata   = $urandom;
      @(negedge aclk);
      @(posedge aclk); #1;
      w0 = we_count;
      exp_w.delete();
      exp_b.delete();
      @(negedge aclk);
      check_reset_outputs();
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      check("awready_after_abort", 64'(awready), 64'd1);
      check("wready_after_abort", 64'(wready), 64'd0);
      @(posedge aclk); #1;
      wvalid = 1'b0;
      repeat (3) begin @(posedge aclk); #1; end
      check("abort_no_writes", 64'(we_count - w0), 64'd0);

      // Random transactions
      wl = '{1, 3, 7, 15};
      for (int t = 0; t < 60; t++) begin
         burst = $urandom_range(0, 9);
         burst = (burst < 2) ? 0 : (burst < 6) ? 1 : (burst < 9) ? 2 : 3;
         size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         len   = (burst == 2 && $urandom_range(0, 4) != 0) ? wl[$urandom_range(0, 3)]
                                                           : $urandom_range(0, 15);
         addr  = $urandom;
         if ($urandom_range(0, 3) == 0) addr[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
         if (burst == 2) addr = addr & ~((32'd1 << size) - 32'd1);
         mode  = $urandom_range(0, 9);
         early = (mode == 0 && len > 0) ? $urandom_range(0, len - 1) : -1;
         run_txn(4'($urandom), addr, len, size, burst, early, mode == 1, $urandom_range(0, 3),
                 g_id, g_resp, wd);
      end

      repeat (2) @(posedge aclk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
